rx_downsampler: RTL
===================

Name: rx_downsampler

Overview:
- Receive-side counterpart of the TX upsampler.
- Takes an upsampled complex I/Q stream and decimates it by 2/4/8/16 (or passes it 1:1 in bypass).
- Decimation is either phase-select (pick one sample per window) or average (integrate-and-dump).
- Results are buffered in a 16-entry output FIFO with valid/ready backpressure toward the baseband receiver.

Parameters:
- DEPTH, 16, output FIFO depth in samples; power of 2.
- IDLE_GAP, 4, consecutive cycles of rx_data_valid=0 that end a stream; range 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx_data_i  in  16  signed I sample
- rx_data_q  in  16  signed Q sample
- rx_data_valid  in  1  input sample strobe; no backpressure to source
- downsampling_factor  in  2  00=2, 01=4, 10=8, 11=16
- bypass_enable  in  1  1 => 1:1, no decimation
- downsample_mode  in  1  0=phase select, 1=average
- phase_offset  in  4  selected slot in phase-select mode, masked to factor-1
- dn_data_i  out  16  decimated I (FIFO head)
- dn_data_q  out  16  decimated Q (FIFO head)
- dn_data_valid  out  1  FIFO non-empty
- dn_data_ready  in  1  consumer accepts head when valid&ready
- sample_count  out  8  outputs pushed into FIFO, wraps 255->0
- buffer_level  out  5  FIFO occupancy 0..16
- overflow  out  1  sticky; set when a result is dropped on full FIFO

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; slot counter, accumulator and FIFO pointers 0; latched config = factor 2, phase select, no bypass, offset 0.
- FSM states:
  - IDLE -> ACTIVE on rx_data_valid=1. That same cycle latches factor, mode, bypass and offset, and the sample counts as slot 0.
  - ACTIVE -> IDLE after IDLE_GAP consecutive cycles with valid=0. Any partial window is discarded; slot and accumulator are cleared.
  - Config inputs are ignored outside the IDLE->ACTIVE transition.
- Slot counter: advances on each valid sample; wraps N-1 -> 0, where N = 1 if bypass else 2<<factor.
- Phase select: when slot == (phase_offset & (N-1)), capture the sample; push it at window end (slot N-1).
- Average:
  - 20-bit signed accumulator; slot 0 loads the sample, other slots add.
  - At slot N-1, result = (acc + sample) >>> log2(N), arithmetic shift, floor rounding, low 16 bits.
  - I and Q are processed independently.
- Bypass: every valid sample is pushed.
- Latency: the result is written into the FIFO at the clock edge that accepts the window's last sample. dn_data_valid rises the following cycle (FIFO is show-ahead, outputs registered from storage).
- FIFO:
  - Push and pop in the same cycle are both performed; level unchanged.
  - Push while full (and no pop that cycle): result dropped, overflow <= 1, sample_count not incremented.
  - Pop while empty: ignored.
  - Pointers wrap modulo DEPTH.
- overflow clears only on reset.
- FIFO keeps draining in IDLE; a new stream does not flush it.
- Reset mid-window or mid-drain: immediate clear of all state; no output pulse.

Optional Feature:
- RX_DS_ROUND_EN.
- Defined: average mode adds N/2 to the sum before the shift (round half up). Results saturate to +32767 if the rounded value exceeds the range.
- Undefined: plain floor truncation as above, no saturation logic.
- Phase select and bypass are unaffected either way.

Decomposition:
- rx_downsampler_pkg:
  - factor encoding constants FACTOR_2..FACTOR_16
  - mode constants MODE_PICK/MODE_AVG
  - FSM state enum (IDLE, ACTIVE)
  - function factor_to_n and function factor_to_shift
- Sub-module rx_ds_fifo: DEPTH-entry 32-bit (I,Q) show-ahead FIFO providing level, full and empty.

Test Plan:
- Phase select: factor=01 (N=4), offset=2, 8 valid samples I=0..7 (Q=-I) -> outputs (2,-2), (6,-6); dn_data_valid first high 1 cycle after the 4th sample.
- Average: factor=00, mode=1, I=3,4 then -3,-4 -> outputs 3 and -4 (floor). With RX_DS_ROUND_EN -> 4 and -3.
- Config latch: factor changed from 00 to 11 mid-stream -> decimation stays by 2 until IDLE_GAP idle cycles, then the next stream decimates by 16.
- Partial window: N=8, 5 samples then IDLE_GAP idle cycles -> no output; the next stream restarts at slot 0.
- Backpressure/overflow: bypass, dn_data_ready=0, 18 valid samples -> buffer_level=16, overflow=1, sample_count=16. Then ready=1 -> 16 pops in order and buffer_level reaches 0.
- Reset mid-operation: rst_n low with buffer_level=5 and slot=3 -> next cycle all outputs 0 and overflow 0.

Source files
------------

// File: rtl/rx_downsampler_pkg.sv
// Shared constants, FSM state type and decimation-factor helpers for rx_downsampler.
package rx_downsampler_pkg;

    localparam logic [1:0] FACTOR_2  = 2'b00;
    localparam logic [1:0] FACTOR_4  = 2'b01;
    localparam logic [1:0] FACTOR_8  = 2'b10;
    localparam logic [1:0] FACTOR_16 = 2'b11;

    localparam logic MODE_PICK = 1'b0;
    localparam logic MODE_AVG  = 1'b1;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_e;

    // Window length in samples; bypass forces a one-sample window.
    function automatic logic [4:0] factor_to_n(input logic [1:0] factor, input logic bypass);
        if (bypass) return 5'd1;
        case (factor)
            FACTOR_2:  return 5'd2;
            FACTOR_4:  return 5'd4;
            FACTOR_8:  return 5'd8;
            FACTOR_16: return 5'd16;
            default:   return 5'd2;
        endcase
    endfunction

    function automatic logic [2:0] factor_to_shift(input logic [1:0] factor, input logic bypass);
        if (bypass) return 3'd0;
        case (factor)
            FACTOR_2:  return 3'd1;
            FACTOR_4:  return 3'd2;
            FACTOR_8:  return 3'd3;
            FACTOR_16: return 3'd4;
            default:   return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/rx_ds_fifo.sv
// Show-ahead FIFO for decimated (I,Q) words; head is valid whenever the FIFO is non-empty.
module rx_ds_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               data_i,
    input  logic                       pop_i,
    output logic [W-1:0]               data_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q;
    logic          push_ok, pop_ok;

    assign full_o  = (level_q == (AW + 1)'(DEPTH));
    assign empty_o = (level_q == '0);
    assign pop_ok  = pop_i & ~empty_o;
    assign push_ok = push_i & (~full_o | pop_ok);

    // NOTE: storage has no reset; the head is forced to zero while empty so stale words never leave.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/rx_downsampler.sv
// I/Q decimator (phase-select or average, 1:1 bypass) feeding a backpressured output FIFO.
// Build option: define RX_DS_ROUND_EN for round-half-up with positive saturation in average mode.
module rx_downsampler
    import rx_downsampler_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int IDLE_GAP = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [15:0]     rx_data_i,
    input  logic signed [15:0]     rx_data_q,
    input  logic                   rx_data_valid,
    input  logic [1:0]             downsampling_factor,
    input  logic                   bypass_enable,
    input  logic                   downsample_mode,
    input  logic [3:0]             phase_offset,
    output logic [15:0]            dn_data_i,
    output logic [15:0]            dn_data_q,
    output logic                   dn_data_valid,
    input  logic                   dn_data_ready,
    output logic [7:0]             sample_count,
    output logic [$clog2(DEPTH):0] buffer_level,
    output logic                   overflow
);
    state_e             state_q, state_d;
    logic [1:0]         factor_q, factor_d;
    logic               mode_q, mode_d, bypass_q, bypass_d;
    logic [3:0]         offset_q, offset_d;
    logic [7:0]         idle_cnt_q, idle_cnt_d;
    logic [3:0]         slot_q, slot_d;
    logic signed [19:0] acc_i_q, acc_i_d, acc_q_q, acc_q_d;
    logic [15:0]        pick_i_q, pick_i_d, pick_q_q, pick_q_d;
    logic [7:0]         count_q, count_d;
    logic               ovf_q, ovf_d;

    logic               push_req, push_en, pop_en, fifo_full, fifo_empty;
    logic [31:0]        push_data, head;

    // The sample that opens a stream is decimated with the config being latched that same cycle.
    logic [1:0]         eff_factor;
    logic               eff_mode, eff_bypass;
    logic [3:0]         eff_offset, last_slot, sel_slot;
    logic [2:0]         shift;
    logic signed [19:0] samp_i, samp_q, sum_i, sum_q;

    assign eff_factor = (state_q == IDLE) ? downsampling_factor : factor_q;
    assign eff_mode   = (state_q == IDLE) ? downsample_mode     : mode_q;
    assign eff_bypass = (state_q == IDLE) ? bypass_enable       : bypass_q;
    assign eff_offset = (state_q == IDLE) ? phase_offset        : offset_q;
    assign last_slot  = 4'(factor_to_n(eff_factor, eff_bypass) - 5'd1);
    assign sel_slot   = eff_offset & last_slot;
    assign shift      = factor_to_shift(eff_factor, eff_bypass);
    assign samp_i     = {{4{rx_data_i[15]}}, rx_data_i};
    assign samp_q     = {{4{rx_data_q[15]}}, rx_data_q};
    assign sum_i      = acc_i_q + samp_i;
    assign sum_q      = acc_q_q + samp_q;

    function automatic logic [15:0] avg_result(input logic signed [19:0] sum, input logic [2:0] sh);
        logic signed [19:0] res;
`ifdef RX_DS_ROUND_EN
        res = (sum + $signed(20'd1 << (sh - 3'd1))) >>> sh;
        if (res > 20'sd32767) res = 20'sd32767;
`else
        res = sum >>> sh;
`endif
        return res[15:0];
    endfunction

    assign pop_en  = dn_data_valid & dn_data_ready;
    assign push_en = push_req & (~fifo_full | pop_en);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        factor_d   = factor_q;
        mode_d     = mode_q;
        bypass_d   = bypass_q;
        offset_d   = offset_q;
        idle_cnt_d = idle_cnt_q;
        slot_d     = slot_q;
        acc_i_d    = acc_i_q;
        acc_q_d    = acc_q_q;
        pick_i_d   = pick_i_q;
        pick_q_d   = pick_q_q;
        push_req   = 1'b0;
        push_data  = '0;

        case (state_q)
            IDLE: begin
                if (rx_data_valid) begin
                    state_d  = ACTIVE;
                    factor_d = downsampling_factor;
                    mode_d   = downsample_mode;
                    bypass_d = bypass_enable;
                    offset_d = phase_offset;
                end
            end
            ACTIVE: begin
                if (!rx_data_valid) begin
                    if (idle_cnt_q == 8'(IDLE_GAP - 1)) begin
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                        slot_d     = '0;
                        acc_i_d    = '0;
                        acc_q_d    = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (rx_data_valid) begin
            idle_cnt_d = '0;
            if (slot_q == sel_slot) begin
                pick_i_d = rx_data_i;
                pick_q_d = rx_data_q;
            end
            acc_i_d = (slot_q == '0) ? samp_i : sum_i;
            acc_q_d = (slot_q == '0) ? samp_q : sum_q;
            if (slot_q == last_slot) begin
                slot_d   = '0;
                push_req = 1'b1;
                if (eff_bypass)
                    push_data = {rx_data_i, rx_data_q};
                else if (eff_mode == MODE_AVG)
                    push_data = {avg_result(sum_i, shift), avg_result(sum_q, shift)};
                else if (slot_q == sel_slot)
                    push_data = {rx_data_i, rx_data_q};
                else
                    push_data = {pick_i_q, pick_q_q};
            end else begin
                slot_d = slot_q + 4'd1;
            end
        end

        count_d = push_en ? count_q + 8'd1 : count_q;
        ovf_d   = ovf_q | (push_req & ~push_en);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            factor_q   <= FACTOR_2;
            mode_q     <= MODE_PICK;
            bypass_q   <= 1'b0;
            offset_q   <= '0;
            idle_cnt_q <= '0;
            slot_q     <= '0;
            acc_i_q    <= '0;
            acc_q_q    <= '0;
            pick_i_q   <= '0;
            pick_q_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            factor_q   <= factor_d;
            mode_q     <= mode_d;
            bypass_q   <= bypass_d;
            offset_q   <= offset_d;
            idle_cnt_q <= idle_cnt_d;
            slot_q     <= slot_d;
            acc_i_q    <= acc_i_d;
            acc_q_q    <= acc_q_d;
            pick_i_q   <= pick_i_d;
            pick_q_q   <= pick_q_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    rx_ds_fifo #(.DEPTH(DEPTH), .W(32)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_en),
        .data_i  (push_data),
        .pop_i   (pop_en),
        .data_o  (head),
        .level_o (buffer_level),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign dn_data_i     = head[31:16];
    assign dn_data_q     = head[15:0];
    assign dn_data_valid = ~fifo_empty;
    assign sample_count  = count_q;
    assign overflow      = ovf_q;

endmodule
